clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl.sv | 121 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Purpose: run-time controller for the fabric clock divider; sequences divisor changes, start and stop on period boundaries.
// Latency: en to first clk_out rise is 1 cycle; a divisor accepted while running takes effect at the next period boundary.
// Backpressure: cfg_ready drops while a divisor is pending and rises again at the boundary that consumes it.
module clk_div_ctrl #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic xfer;
  logic legal;
  logic boundary;

  assign xfer     = cfg_valid && !pend_v_q;
  assign legal    = (cfg_div >= WIDTH'(2));
  assign boundary = (cnt_q == (div_q - WIDTH'(1)));

  // Next-state: counter advance, boundary handling, and divisor intake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    err_d     = xfer && !legal;

    if (state_q == IDLE) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      // In IDLE there is no period in flight, so a legal divisor lands directly
      if (xfer && legal) begin
        div_d = cfg_div;
      end
      if (en) begin
        state_d   = RUN;
        cnt_d     = '0;
        clk_out_d = 1'b1;
      end
    end else begin
      if (!boundary) begin
        cnt_d     = cnt_q + WIDTH'(1);
        clk_out_d = ((cnt_q + WIDTH'(1)) < (div_q >> 1));
      end else begin
        tick_d = 1'b1;
        if (pend_v_q) begin
          div_d    = pend_q;
          pend_v_d = 1'b0;
        end
        cnt_d = '0;
        if (en) begin
          clk_out_d = 1'b1;
        end else begin
          state_d   = IDLE;
          clk_out_d = 1'b0;
        end
      end
      // Mid-run offers are parked until the next boundary; pend_v_q was 0 if xfer is set
      if (xfer && legal) begin
        pend_d   = cfg_div;
        pend_v_d = 1'b1;
      end
    end
  end

  // State and output registers; reset forces clk_out low even mid-high-phase
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready   = !pend_v_q;
  assign cfg_err     = err_q;
  assign clk_out     = clk_out_q;
  assign period_tick = tick_q;
  assign running     = (state_q == RUN);
  assign cur_div     = div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int W = 28;

  logic         clk_in;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         period_tick;
  logic         running;
  logic [W-1:0] cur_div;

  int total;
  int bad;

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .running     (running),
    .cur_div     (cur_div)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: each started period is laid out as a waveform queue
  bit q_wave[$];
  bit m_run;
  int m_div;
  int m_pend;
  bit m_pend_v;
  bit m_xfer;
  bit e_clk;
  bit e_tick;
  bit e_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_wave.delete();
    m_run = 0; m_div = 4; m_pend = 0; m_pend_v = 0;
    m_xfer = 0; e_clk = 0; e_tick = 0; e_err = 0;
  endtask

  task automatic fill_period(input int d);
    for (int i = 0; i < d; i++) q_wave.push_back(i < d / 2);
  endtask

  task automatic model_edge(input bit e, input bit v, input int d);
    bit legal;
    m_xfer = v && !m_pend_v;
    legal  = (d >= 2);
    e_err  = m_xfer && !legal;
    e_tick = 0;
    if (!m_run) begin
      if (m_xfer && legal) m_div = d;
      if (e) begin
        m_run = 1;
        fill_period(m_div);
        e_clk = q_wave.pop_front();
      end else begin
        e_clk = 0;
      end
    end else begin
      if (q_wave.size() != 0) begin
        e_clk = q_wave.pop_front();
      end else begin
        e_tick = 1;
        if (m_pend_v) begin
          m_div = m_pend;
          m_pend_v = 0;
        end
        if (e) begin
          fill_period(m_div);
          e_clk = q_wave.pop_front();
        end else begin
          m_run = 0;
          e_clk = 0;
        end
      end
      if (m_xfer && legal) begin
        m_pend = d;
        m_pend_v = 1;
      end
    end
  endtask

  task automatic cmp_model();
    check("clk_out", {31'b0, clk_out}, {31'b0, e_clk});
    check("period_tick", {31'b0, period_tick}, {31'b0, e_tick});
    check("cfg_err", {31'b0, cfg_err}, {31'b0, e_err});
    check("running", {31'b0, running}, {31'b0, m_run});
    check("cur_div", {4'b0, cur_div}, m_div);
    check("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_pend_v});
  endtask

  task automatic step(input bit e, input bit v, input int d);
    en = e;
    cfg_valid = v;
    cfg_div = W'(d);
    model_edge(e, v, d);
    @(posedge clk_in);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst clk_out", {31'b0, clk_out}, 0);
    check("rst cur_div", {4'b0, cur_div}, 4);
    check("rst cfg_ready", {31'b0, cfg_ready}, 1);
    check("rst running", {31'b0, running}, 0);
    check("rst tick", {31'b0, period_tick}, 0);
    check("rst cfg_err", {31'b0, cfg_err}, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit en; bit vld; int div;
    bit clk; bit tick; bit run; int cur; bit rdy; bit err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int hi;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

    // en,vld,div | clk,tick,run,cur,rdy,err
    tbl[0]  = '{0, 1, 5, 0, 0, 0, 5, 1, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 1, 5, 1, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 1, 5, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 5, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 5, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 5, 1, 0};
    tbl[6]  = '{1, 0, 0, 1, 1, 1, 5, 1, 0};
    tbl[7]  = '{1, 1, 1, 1, 0, 1, 5, 1, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, 1, 5, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 5, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 5, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 5, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 5, 1, 0};
    tbl[13] = '{1, 1, 0, 1, 0, 1, 5, 1, 1};

    // Default divisor waveform straight out of reset
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    check("d4 tick after 8", {31'b0, period_tick}, 0);

    // Table: idle load of 5, illegal offers, stop at boundary
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].vld, tbl[i].div);
      check($sformatf("tbl%0d clk", i), {31'b0, clk_out}, {31'b0, tbl[i].clk});
      check($sformatf("tbl%0d tick", i), {31'b0, period_tick}, {31'b0, tbl[i].tick});
      check($sformatf("tbl%0d run", i), {31'b0, running}, {31'b0, tbl[i].run});
      check($sformatf("tbl%0d cur", i), {4'b0, cur_div}, tbl[i].cur);
      check($sformatf("tbl%0d rdy", i), {31'b0, cfg_ready}, {31'b0, tbl[i].rdy});
      check($sformatf("tbl%0d err", i), {31'b0, cfg_err}, {31'b0, tbl[i].err});
    end

    // Mid-run divisor change with a second offer stalled behind it
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 6);
    check("chg ready low", {31'b0, cfg_ready}, 0);
    step(1, 1, 8);
    check("chg stall ready", {31'b0, cfg_ready}, 0);
    check("chg cur still 4", {4'b0, cur_div}, 4);
    step(1, 1, 8);
    check("chg boundary tick", {31'b0, period_tick}, 1);
    check("chg cur 6", {4'b0, cur_div}, 6);
    check("chg ready back", {31'b0, cfg_ready}, 1);
    hi = int'(clk_out);
    step(1, 1, 8);
    check("chg 8 accepted", {31'b0, cfg_ready}, 0);
    hi += int'(clk_out);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      hi += int'(clk_out);
    end
    check("chg d6 high count", hi, 3);
    step(1, 0, 0);
    check("chg cur 8", {4'b0, cur_div}, 8);

    // Drop en at cnt=0: full period completes, then restart
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
    check("stop still running", {31'b0, running}, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("stop tick", {31'b0, period_tick}, 1);
    check("stop running", {31'b0, running}, 0);
    check("stop clk", {31'b0, clk_out}, 0);
    step(1, 0, 0);
    check("restart clk", {31'b0, clk_out}, 1);

    // Asynchronous reset in a high phase with a divisor pending
    do_reset();
    step(0, 1, 6);
    step(1, 0, 0);
    step(1, 1, 9);
    check("pre-rst clk high", {31'b0, clk_out}, 1);
    check("pre-rst pending", {31'b0, cfg_ready}, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst clk_out", {31'b0, clk_out}, 0);
    check("arst cur_div", {4'b0, cur_div}, 4);
    check("arst ready", {31'b0, cfg_ready}, 1);
    model_reset();
    en = 1'b0; cfg_valid = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    step(0, 0, 0);
    check("post-rst ready", {31'b0, cfg_ready}, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    check("pending dropped", {4'b0, cur_div}, 4);

    // Randomized traffic against the model
    do_reset();
    begin
      bit r_en;
      bit r_v;
      int r_d;
      r_en = 0; r_v = 0; r_d = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) r_en = !r_en;
        if (!(r_v && !m_xfer)) begin
          r_v = ($urandom_range(0, 3) == 0);
          r_d = $urandom_range(0, 9);
        end
        step(r_en, r_v, r_d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
